// File: rtl/fpu_dispatch_pkg.sv
// Types shared by the FPU dispatcher and its instruction queue.
package fpu_dispatch_pkg;

    import fpu_params::*;

    typedef struct packed {
        logic [FPU_OP_WIDTH-1:0]       op;
        logic [FPU_REG_ADDR_WIDTH-1:0] x1;
        logic [FPU_REG_ADDR_WIDTH-1:0] x2;
        logic [FPU_REG_ADDR_WIDTH-1:0] y;
        logic [31:0]                   data;
    } dispatch_entry_t;

    typedef enum logic {StIdle, StRun} dispatch_state_t;

endpackage

// File: rtl/fpu_params.sv
// Shared FPU encoding constants: instruction field widths and opcode values.
package fpu_params;

    localparam int unsigned FPU_OP_WIDTH       = 4;
    localparam int unsigned FPU_REG_ADDR_WIDTH = 5;

    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FADD  = 4'd0;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FSUB  = 4'd1;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FMUL  = 4'd2;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FDIV  = 4'd3;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FSQRT = 4'd4;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FCLT  = 4'd5;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FCEQ  = 4'd6;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FCLE  = 4'd7;
    localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FMV   = 4'd8;

endpackage

// File: rtl/fpu_dispatch_fifo.sv
// Instruction queue for the FPU dispatcher; the head is held in a register that is
// preloaded with the next entry so a pop exposes the following instruction with no bubble.
module fpu_dispatch_fifo
    import fpu_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  dispatch_entry_t         din_i,
    input  logic                    pop_i,
    output dispatch_entry_t         head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    dispatch_entry_t mem_q [DEPTH];
    dispatch_entry_t head_q, head_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign head_o  = head_q;
    assign count_o = count_q;

    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && (count_q != '0);
        wptr_d  = wptr_q + PtrW'(push_ok);
        rptr_d  = rptr_q + PtrW'(pop_ok);
        count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
        head_d  = head_q;
        // A push into a queue that is (or is becoming) empty is its own new head.
        if (push_ok && ((count_q - CntW'(pop_ok)) == '0)) begin
            head_d = din_i;
        end else if (pop_ok && (count_d != '0)) begin
            head_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Queues FPU instructions and issues them one at a time on a ready/valid FPU handshake.
// Define FPU_DISPATCH_TIMEOUT_EN to drop an instruction the FPU never completes.
module fpu_dispatch
    import fpu_params::*, fpu_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [FPU_OP_WIDTH-1:0]       req_op,
    input  logic [FPU_REG_ADDR_WIDTH-1:0] req_x1,
    input  logic [FPU_REG_ADDR_WIDTH-1:0] req_x2,
    input  logic [FPU_REG_ADDR_WIDTH-1:0] req_y,
    input  logic [31:0]                   req_data,
    output logic [FPU_REG_ADDR_WIDTH-1:0] fpu_x1,
    output logic [FPU_REG_ADDR_WIDTH-1:0] fpu_x2,
    output logic [FPU_REG_ADDR_WIDTH-1:0] fpu_y,
    output logic [FPU_OP_WIDTH-1:0]       fpu_operation,
    output logic [31:0]                   fpu_in_data,
    output logic                          fpu_ready,
    input  logic                          fpu_valid,
    input  logic [31:0]                   fpu_out_data,
    input  logic                          fpu_cond,
    output logic                          rsp_valid,
    output logic [FPU_OP_WIDTH-1:0]       rsp_op,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_cond,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    dispatch_state_t             state_q, state_d;
    dispatch_entry_t             req_entry, head;
    logic [CntW-1:0]             count, count_after;
    logic                        full, push, pop, valid_pop, tmo_pop, running;
    logic                        rsp_valid_q;
    logic [FPU_OP_WIDTH-1:0]     rsp_op_q;
    logic [31:0]                 rsp_data_q;

    assign running   = (state_q == StRun);
    assign req_ready = rstn && !full;
    assign push      = req_valid && req_ready;
    assign valid_pop = running && fpu_valid;
    assign pop       = valid_pop || tmo_pop;
    assign req_entry = '{op: req_op, x1: req_x1, x2: req_x2, y: req_y, data: req_data};

    fpu_dispatch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .push_i  (push),
        .din_i   (req_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (full)
    );

    // Occupancy after this cycle's traffic; a same-cycle push keeps RUN alive.
    assign count_after = count + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (count != '0) state_d = StRun;
            StRun:  if (tmo_pop || (pop && (count_after == '0))) state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= valid_pop;
            if (valid_pop) begin
                rsp_op_q   <= head.op;
                rsp_data_q <= fpu_out_data;
            end
        end
    end

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_q;

    assign tmo_pop     = running && !fpu_valid && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        if (!running || pop) tmo_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_q | tmo_pop;
        end
    end
`else
    assign tmo_pop     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign fpu_ready     = running;
    assign fpu_x1        = head.x1;
    assign fpu_x2        = head.x2;
    assign fpu_y         = head.y;
    assign fpu_operation = head.op;
    assign fpu_in_data   = head.data;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_op        = rsp_op_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_cond      = fpu_cond;
    assign busy          = (count != '0) || running;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: directed scenarios plus random traffic against a
// queue-based reference model of the dispatcher.
module tb_fpu_dispatch;

    import fpu_params::*;
    import fpu_dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic clk, rstn, req_valid, req_ready, fpu_ready, fpu_valid, fpu_cond;
    logic rsp_valid, rsp_cond, busy, err_timeout;
    logic [FPU_OP_WIDTH-1:0] req_op, fpu_operation, rsp_op;
    logic [FPU_REG_ADDR_WIDTH-1:0] req_x1, req_x2, req_y, fpu_x1, fpu_x2, fpu_y;
    logic [31:0] req_data, fpu_in_data, fpu_out_data, rsp_data;

    fpu_dispatch #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_x1        (req_x1),
        .req_x2        (req_x2),
        .req_y         (req_y),
        .req_data      (req_data),
        .fpu_x1        (fpu_x1),
        .fpu_x2        (fpu_x2),
        .fpu_y         (fpu_y),
        .fpu_operation (fpu_operation),
        .fpu_in_data   (fpu_in_data),
        .fpu_ready     (fpu_ready),
        .fpu_valid     (fpu_valid),
        .fpu_out_data  (fpu_out_data),
        .fpu_cond      (fpu_cond),
        .rsp_valid     (rsp_valid),
        .rsp_op        (rsp_op),
        .rsp_data      (rsp_data),
        .rsp_cond      (rsp_cond),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending instructions in push order, head at index 0.
    dispatch_entry_t         q[$];
    bit                      m_run, m_rsp_valid, m_err;
    logic [FPU_OP_WIDTH-1:0] m_rsp_op;
    logic [31:0]             m_rsp_data;
    int                      m_wait;
    int                      n_cmp, n_err, rsp_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic dispatch_entry_t mk(input logic [FPU_OP_WIDTH-1:0] op, input int x1,
                                           input int x2, input int y, input logic [31:0] d);
        dispatch_entry_t e;
        e.op   = op;
        e.x1   = FPU_REG_ADDR_WIDTH'(x1);
        e.x2   = FPU_REG_ADDR_WIDTH'(x2);
        e.y    = FPU_REG_ADDR_WIDTH'(y);
        e.data = d;
        return e;
    endfunction

    function automatic dispatch_entry_t rnd_entry();
        return mk(FPU_OP_WIDTH'($urandom_range(0, 8)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom);
    endfunction

    task automatic check_outputs();
        if (rsp_valid) rsp_seen++;
        chk("fpu_ready", 32'(fpu_ready), 32'(m_run));
        chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("busy", 32'(busy), 32'((q.size() != 0) || m_run));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("rsp_op", 32'(rsp_op), 32'(m_rsp_op));
        chk("rsp_data", rsp_data, m_rsp_data);
        if (m_rsp_valid) chk("rsp_cond", 32'(rsp_cond), 32'(fpu_cond));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        if (m_run) begin
            chk("fpu_operation", 32'(fpu_operation), 32'(q[0].op));
            chk("fpu_x1", 32'(fpu_x1), 32'(q[0].x1));
            chk("fpu_x2", 32'(fpu_x2), 32'(q[0].x2));
            chk("fpu_y", 32'(fpu_y), 32'(q[0].y));
            chk("fpu_in_data", fpu_in_data, q[0].data);
        end
    endtask

    // vmode: 0 = no valid, 1 = valid, 2 = valid with probability 1/3.
    task automatic run_cycle(input bit push_en, input dispatch_entry_t e, input int vmode,
                             input logic [31:0] odata, input bit cond);
        bit push, vpop, tpop, was_run;
        int sz_before;
        @(negedge clk);
        req_valid    = push_en;
        req_op       = e.op;
        req_x1       = e.x1;
        req_x2       = e.x2;
        req_y        = e.y;
        req_data     = e.data;
        fpu_valid    = (vmode == 1) || ((vmode == 2) && ($urandom_range(0, 2) == 0));
        fpu_out_data = odata;
        fpu_cond     = cond;
        #1;
        check_outputs();
        push      = push_en && (q.size() < DEPTH);
        vpop      = m_run && fpu_valid;
        tpop      = TmoEn && m_run && !fpu_valid && (m_wait == TMO - 1);
        sz_before = q.size();
        m_rsp_valid = vpop;
        if (vpop) begin
            m_rsp_op   = q[0].op;
            m_rsp_data = odata;
        end
        if (vpop || tpop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (tpop) m_err = 1'b1;
        was_run = m_run;
        if (!m_run)    m_run = (sz_before != 0);
        else if (tpop) m_run = 1'b0;
        else if (vpop) m_run = (q.size() != 0);
        m_wait = (was_run && m_run && !vpop) ? m_wait + 1 : 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 0, $urandom, 1'(($urandom_range(0, 1))));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = 1'b0;
        fpu_valid = 1'b0;
        #1;
        chk("rst_fpu_ready", 32'(fpu_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_op", 32'(rsp_op), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_fpu_x1", 32'(fpu_x1), 32'd0);
        chk("rst_fpu_in_data", fpu_in_data, 32'd0);
        repeat (cycles) @(negedge clk);
        rstn = 1'b1;
        q.delete();
        m_run       = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_op    = '0;
        m_rsp_data  = '0;
        m_err       = 1'b0;
        m_wait      = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        dispatch_entry_t a, b;
        int base, lows;
        rstn = 1'b0;
        {req_valid, fpu_valid, fpu_cond} = '0;
        {req_op, req_x1, req_x2, req_y, req_data, fpu_out_data} = '0;
        n_cmp = 0;
        n_err = 0;
        rsp_seen = 0;
        do_reset(2);

        // Single FADD, FPU answers 3 cycles after fpu_ready rises.
        run_cycle(1'b1, mk(FPU_OP_FADD, 1, 2, 3, 32'h0), 0, 32'h0, 1'b0);
        idle(2);
        chk("fadd_ready_rise", 32'(fpu_ready), 32'd1);
        idle(2);
        run_cycle(1'b0, '0, 1, 32'h4040_0000, 1'b0);
        run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
        chk("fadd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fadd_rsp_data", rsp_data, 32'h4040_0000);
        chk("fadd_rsp_op", 32'(rsp_op), 32'(FPU_OP_FADD));
        idle(1);
        chk("fadd_busy_after", 32'(busy), 32'd0);

        // Four back-to-back pushes fill the queue; completions issue with no bubble.
        base = rsp_seen;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, mk(FPU_OP_WIDTH'(i + 1), i, i + 4, i + 8, 32'(i * 7)), 0, 0, 1'b0);
        end
        run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
        chk("full_req_ready", 32'(req_ready), 32'd0);
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
            if (!fpu_ready) lows++;
            run_cycle(1'b0, '0, 1, 32'(32'h1000 + i), 1'b0);
            if (!fpu_ready) lows++;
        end
        idle(1);
        chk("b2b_ready_gaps", 32'(lows), 32'd0);
        chk("b2b_rsp_count", 32'(rsp_seen - base), 32'd4);
        idle(2);

        // FCLT: condition register updated the cycle after valid.
        run_cycle(1'b1, mk(FPU_OP_FCLT, 5, 6, 0, 32'h0), 0, 32'h0, 1'b0);
        idle(2);
        run_cycle(1'b0, '0, 1, 32'h0, 1'b0);
        run_cycle(1'b0, '0, 0, 32'h0, 1'b1);
        chk("fclt_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fclt_rsp_cond", 32'(rsp_cond), 32'd1);
        idle(2);

        // Push coincident with the final pop keeps RUN going.
        a = mk(FPU_OP_FMUL, 3, 4, 5, 32'hA);
        b = mk(FPU_OP_FDIV, 9, 10, 11, 32'hB);
        run_cycle(1'b1, a, 0, 32'h0, 1'b0);
        idle(2);
        run_cycle(1'b1, b, 1, 32'h5555_0000, 1'b0);
        run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
        chk("final_pop_push_ready", 32'(fpu_ready), 32'd1);
        chk("final_pop_push_op", 32'(fpu_operation), 32'(FPU_OP_FDIV));
        run_cycle(1'b0, '0, 1, 32'h6666_0000, 1'b0);
        idle(3);

        // Reset with one op in flight and three queued.
        for (int i = 0; i < 4; i++) run_cycle(1'b1, rnd_entry(), 0, 32'h0, 1'b0);
        idle(1);
        do_reset(1);
        run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
        chk("rst_release_req_ready", 32'(req_ready), 32'd1);
        chk("rst_release_busy", 32'(busy), 32'd0);
        idle(2);

`ifdef FPU_DISPATCH_TIMEOUT_EN
        // FPU never answers: head dropped after TMO RUN cycles, next op after one low cycle.
        run_cycle(1'b1, mk(FPU_OP_FSQRT, 1, 1, 1, 32'h1), 0, 32'h0, 1'b0);
        run_cycle(1'b1, mk(FPU_OP_FMV, 2, 2, 2, 32'h2), 0, 32'h0, 1'b0);
        for (int i = 0; i < TMO; i++) run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
        run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
        chk("tmo_err", 32'(err_timeout), 32'd1);
        chk("tmo_ready_low", 32'(fpu_ready), 32'd0);
        chk("tmo_no_rsp", 32'(rsp_valid), 32'd0);
        run_cycle(1'b0, '0, 0, 32'h0, 1'b0);
        chk("tmo_next_ready", 32'(fpu_ready), 32'd1);
        chk("tmo_next_op", 32'(fpu_operation), 32'(FPU_OP_FMV));
        run_cycle(1'b0, '0, 1, 32'h7, 1'b0);
        idle(2);
        do_reset(1);
`endif

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset(2);
            run_cycle(1'($urandom_range(0, 1)), rnd_entry(), 2, $urandom,
                      1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++) run_cycle(1'b0, '0, 1, $urandom, 1'($urandom_range(0, 1)));
        chk("drain_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
